sample_player: RTL
==================

// Module: sample_player
// PURPOSE
//  Synthesizable, parametrised stimulus engine for the FSE-LMS datapath.
//  - Plays a preloaded sample table into the equaliser input x, NCH channels wide, at a programmable sample rate.
//  - Supports one-shot and loop modes, with start/stop control and valid/busy/done status.
//  - Sits in front of top; drives x so that on-board and on-FPGA runs reproduce the simulated input sequence.
// PARAMETERS
//  NB      8     bits per channel sample; signed, same format as top NBin
//  NCH     1     channel count; the sample word is NCH*NB bits, channel 0 in the LSBs
//  DEPTH   1024  table depth in words; AW = $clog2(DEPTH) (localparam)
//  NBDIV   8     width of rate_div
// PORTS
//  clkA        in   1         system clock, rising edge
//  reset       in   1         asynchronous, active-low reset
//  wr_en       in   1         table write strobe
//  wr_addr     in   AW        table write address
//  wr_data     in   NCH*NB    table write data
//  start       in   1         one-cycle pulse; starts playback
//  stop        in   1         one-cycle pulse; aborts playback
//  mode_loop   in   1         0 = one-shot, 1 = continuous wrap
//  rate_div    in   NBDIV     one sample every rate_div+1 clocks
//  length      in   AW+1      number of samples to play; clamped to DEPTH
//  x           out  NCH*NB    sample output; holds its value between strobes
//  x_valid     out  1         one-cycle strobe: x carries a new sample
//  busy        out  1         playback active
//  done        out  1         one-cycle pulse at end of one-shot playback
//  ptr         out  AW        address of the next sample to be read
// BEHAVIOUR
//  - Reset (async, reset=0): x=0, x_valid=0, busy=0, done=0, ptr=0, FSM=IDLE, divider=0.
//    Table contents are not reset.
//  - Reset asserted mid-run forces all of the above immediately; no done pulse.
//  - FSM states: IDLE, RUN.
//    - IDLE -> RUN on start with clamped length > 0.
//    - RUN -> IDLE on the last one-shot sample, or on stop.
//  - Sampled at start and held for the whole run: mode_loop, rate_div, length.
//    Changing these inputs mid-run has no effect.
//  - Table is synchronous-read.
//    - In RUN, a read of ptr is issued when the divider equals 0.
//    - The next cycle registers x and pulses x_valid.
//    - The divider counts 0..rate_div and then wraps to 0.
//    - Latency: start at cycle T gives the first x_valid at T+2; later strobes every rate_div+1 cycles.
//  - busy=1 from T+1 through the cycle of the final x_valid.
//    In loop mode busy stays 1 until stop.
//  - One-shot mode: done pulses in the same cycle as the last x_valid. ptr returns to 0.
//  - Loop mode: ptr wraps from length-1 to 0; done never asserts.
//  - stop: FSM -> IDLE next cycle, busy=0, no further x_valid (including any read in flight), x holds its last value, ptr=0, no done.
//  - start and stop in the same cycle: stop wins, start ignored.
//  - start while busy is ignored.
//  - length=0: no RUN; done pulses at T+1; x_valid never asserts.
//  - length>DEPTH is clamped to DEPTH.
//  - Write during RUN is allowed. Write and read of the same address in the same cycle returns the OLD data.
// CONFIGURATION
//  PLAYER_CAPTURE_EN defined: adds a capture table of DEPTH x NBCAP (localparam NBCAP = 8, top NBout) and these ports:
//    cap_in       in   NBCAP
//    cap_rd_addr  in   AW
//    cap_rd_data  out  NBCAP   1-cycle synchronous read
//    cap_count    out  AW+1    saturates at DEPTH; cleared by start
//  - Capture behaviour: on every x_valid, cap_in is written at address cap_count, then cap_count increments.
//    This records the DUT output y aligned to each input sample.
//  - PLAYER_CAPTURE_EN undefined: no capture table, no capture ports; playback behaviour is identical.
// TESTING
//  1. Load 0x01,0x02,0x03,0xFE; length=4, rate_div=0, one-shot, start at T
//     -> x_valid at T+2..T+5 with x = 01,02,03,FE; done at T+5; busy=0 at T+6; x holds FE.
//  2. Same table, rate_div=9 -> x_valid at T+2, T+12, T+22, T+32; x constant between strobes.
//  3. Loop mode, length=3, rate_div=0 -> x = 01,02,03,01,02,...; no done; stop -> x_valid=0 and busy=0 from the next cycle.
//  4. length=0 -> done at T+1, no x_valid.
//     length=DEPTH+5 -> exactly DEPTH strobes, then done.
//     start+stop in the same cycle -> stays IDLE.
//  5. reset=0 asserted mid-run (async, between edges) -> x=0, x_valid=0, busy=0, ptr=0 immediately; after release, start replays from 0.
//  6. PLAYER_CAPTURE_EN: cap_in = ~x tracked per strobe, length=4 -> cap_count=4; cap_rd_addr 0..3 returns FE,FD,FC,01.

Source files
------------

// File: rtl/sample_player_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_player_if
// Description : Bus interface of the sample_player stimulus engine. Carries
//               the table write port, playback control, sample output and
//               status. With PLAYER_CAPTURE_EN defined it also carries the
//               capture-table ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_player_if #(
  parameter int NB    = 8,
  parameter int NCH   = 1,
  parameter int DEPTH = 1024,
  parameter int NBDIV = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = NCH * NB;

  // Table write port
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;

  // Playback control
  logic             start;
  logic             stop;
  logic             mode_loop;
  logic [NBDIV-1:0] rate_div;
  logic [AW:0]      length;

  // Sample output and status
  logic [W-1:0]     x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [AW-1:0]    ptr;

`ifdef PLAYER_CAPTURE_EN
  localparam int NBCAP = 8;

  // Capture table ports
  logic [NBCAP-1:0] cap_in;
  logic [AW-1:0]    cap_rd_addr;
  logic [NBCAP-1:0] cap_rd_data;
  logic [AW:0]      cap_count;

  modport master (
    output wr_en, wr_addr, wr_data,
    output start, stop, mode_loop, rate_div, length,
    output cap_in, cap_rd_addr,
    input  x, x_valid, busy, done, ptr,
    input  cap_rd_data, cap_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  start, stop, mode_loop, rate_div, length,
    input  cap_in, cap_rd_addr,
    output x, x_valid, busy, done, ptr,
    output cap_rd_data, cap_count
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data,
    output start, stop, mode_loop, rate_div, length,
    input  x, x_valid, busy, done, ptr
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  start, stop, mode_loop, rate_div, length,
    output x, x_valid, busy, done, ptr
  );
`endif

endinterface
`default_nettype wire

// File: rtl/sample_player.sv
`default_nettype none
// ============================================================================
// Module      : sample_player
// Description : Stimulus engine for the FSE-LMS datapath. Plays a preloaded
//               sample table (NCH channels of NB bits, channel 0 in the LSBs)
//               onto x at one sample every rate_div+1 clocks, in one-shot or
//               loop mode, with start/stop control and busy/done status.
//               Optional feature macro: PLAYER_CAPTURE_EN adds a capture
//               table that records cap_in on every x_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_player #(
  parameter int NB    = 8,
  parameter int NCH   = 1,
  parameter int DEPTH = 1024,
  parameter int NBDIV = 8
) (
  input  wire            clkA,
  input  wire            reset,   // asynchronous, active low
  sample_player_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = NCH * NB;

  // DEPTH expressed in the width of the length port, used for clamping
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [W-1:0]     mem [DEPTH];

  state_t           state_q;
  logic [AW-1:0]    ptr_q;
  logic [NBDIV-1:0] div_q;
  logic [NBDIV-1:0] rate_q;
  logic [AW:0]      len_q;
  logic             loop_q;
  logic [W-1:0]     x_q;
  logic             x_valid_q;
  logic             busy_q;
  logic             done_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [AW:0]      len_clamp_d;
  logic             start_ok_d;
  logic             is_last_d;
  logic [AW-1:0]    ptr_inc_d;
  logic [NBDIV-1:0] div_nxt_d;

  // Oversized lengths play the whole table
  assign len_clamp_d = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;

  // A start is honoured only from a fully idle engine; a simultaneous stop
  // cancels it. busy_q still high in IDLE covers the cycle of the final
  // one-shot strobe, where a start must also be ignored.
  assign start_ok_d = bus.start && !bus.stop && (state_q == IDLE) && !busy_q;

  // The sample at ptr is the final one of the held length
  assign is_last_d = ({1'b0, ptr_q} == (len_q - (AW+1)'(1)));

  assign ptr_inc_d = ptr_q + AW'(1);

  // Divider counts 0..rate and wraps
  assign div_nxt_d = (div_q == rate_q) ? '0 : (div_q + NBDIV'(1));

  // --------------------------------------------------------------------------
  // Sample table write port (contents are deliberately not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clkA) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Playback FSM: the table read lands directly in x_q, so a read issued with
  // the divider at 0 is visible as x/x_valid on the next cycle. A write to the
  // same address on that edge returns the old word.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkA or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      div_q     <= '0;
      rate_q    <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          ptr_q  <= '0;
          div_q  <= '0;
          if (start_ok_d) begin
            if (len_clamp_d == '0) begin
              // Nothing to play: report completion straight away
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              loop_q  <= bus.mode_loop;
              rate_q  <= bus.rate_div;
              len_q   <= len_clamp_d;
            end
          end
        end

        RUN: begin
          if (bus.stop) begin
            // Abort: suppress the pending read, keep x, rewind the pointer
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            div_q   <= '0;
          end else begin
            div_q <= div_nxt_d;
            if (div_q == '0) begin
              x_q       <= mem[ptr_q];
              x_valid_q <= 1'b1;
              if (is_last_d) begin
                ptr_q <= '0;
                if (!loop_q) begin
                  // busy_q stays high for the cycle of this final strobe
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                end
              end else begin
                ptr_q <= ptr_inc_d;
              end
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ptr     = ptr_q;

`ifdef PLAYER_CAPTURE_EN
  // --------------------------------------------------------------------------
  // Capture table: records cap_in alongside every played sample
  // --------------------------------------------------------------------------
  localparam int NBCAP = 8;

  logic [NBCAP-1:0] cap_mem [DEPTH];
  logic [AW:0]      cap_count_q;
  logic [NBCAP-1:0] cap_rd_q;
  logic             cap_we_d;

  // Writes stop once the table is full; the count saturates at DEPTH
  assign cap_we_d = x_valid_q && (cap_count_q < DEPTH_L);

  // Capture table write and synchronous read-back
  always_ff @(posedge clkA) begin
    if (cap_we_d) begin
      cap_mem[cap_count_q[AW-1:0]] <= bus.cap_in;
    end
    cap_rd_q <= cap_mem[bus.cap_rd_addr];
  end

  // Capture count: cleared by an accepted start, advanced per strobe
  always_ff @(posedge clkA or negedge reset) begin
    if (!reset) begin
      cap_count_q <= '0;
    end else if (start_ok_d) begin
      cap_count_q <= '0;
    end else if (cap_we_d) begin
      cap_count_q <= cap_count_q + (AW+1)'(1);
    end
  end

  assign bus.cap_rd_data = cap_rd_q;
  assign bus.cap_count   = cap_count_q;
`endif

endmodule
`default_nettype wire
